operand_mux_scheduler: RTL and testbench
========================================

OPERAND_MUX_SCHEDULER -- requirements
Module: operand_mux_scheduler

Interface
REQ-001 Parameter TMO_CYCLES, default 255: WAIT-state cycles allowed before timeout abort; legal range 1..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 8: width of the timeout counter.
REQ-003 One clock, CLK; reset RST_N is asynchronous and active-low.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 REQ  input  3  per-requester level request; bit i is requester i and mux input D_i.
REQ-007 DONE  input  1  single-cycle completion strobe from the shared FP unit.
REQ-008 MS  output  2  select for the shared 3:1 operand mux: 00=D_0, 01=D_1, 10=D_2; value 11 never driven.
REQ-009 GNT  output  3  one-hot grant; high LAUNCH through WAIT.
REQ-010 START_OP  output  1  one-cycle start pulse to the FP unit.
REQ-011 ACK  output  3  one-hot, one-cycle completion acknowledge to the granted requester.
REQ-012 ERR  output  1  one-cycle timeout-abort flag.
REQ-013 BUSY  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, LAUNCH, WAIT, RELEASE; all outputs registered.
REQ-015 IDLE: if REQ != 0 at a rising edge, next state LAUNCH; MS and GNT load the winner on that edge; otherwise remain in IDLE.
REQ-016 Arbitration SHALL be round-robin: search starts at LAST+1 (mod 3), where LAST is the most recently granted index.
REQ-017 LAUNCH: START_OP=1 for exactly this one cycle; unconditional transition to WAIT; DONE sampled in LAUNCH is ignored.
REQ-018 WAIT: DONE=1 at an edge -> RELEASE with ACK[sel]=1 and ERR=0; LAST<=sel; GNT cleared.
REQ-019 RELEASE: lasts exactly one cycle, then IDLE; REQ is not sampled in RELEASE, so a requester dropping REQ on ACK is never regranted.
REQ-020 MS SHALL be held stable from LAUNCH until the next grant, including through RELEASE and IDLE.
REQ-021 Deasserting REQ during LAUNCH or WAIT SHALL NOT abort the transaction; it completes normally.
REQ-022 Minimum turnaround: REQ seen at edge k -> START_OP high cycle k+1 -> DONE accepted no earlier than edge k+2 -> ACK high the following cycle -> earliest next grant two edges after ACK.
REQ-023 REQ changes in WAIT SHALL have no effect on MS or GNT.

Reset
REQ-024 RST_N low SHALL immediately force: state IDLE, MS=00, GNT=000, ACK=000, START_OP=0, ERR=0, BUSY=0, LAST=2 (first grant order 0,1,2), timeout counter 0.
REQ-025 Reset asserted mid-transaction SHALL abandon it without ACK or ERR; the FP unit result is discarded.
REQ-026 Reset release SHALL take effect at the first rising edge with RST_N high.

Configuration
REQ-027 Macro OPERAND_MUX_SCHEDULER_TIMEOUT_EN defined: counter clears on entry to WAIT and increments each WAIT cycle; reaching TMO_CYCLES without DONE -> RELEASE with ERR=1, ACK=000, LAST<=sel.
REQ-028 With the macro defined, DONE and timeout on the same edge SHALL resolve as DONE (ACK=1, ERR=0).
REQ-029 Macro undefined: no counter is built; WAIT persists until DONE; ERR is tied to 0; parameters TMO_CYCLES and CNT_W are unused.

Verification
REQ-030 Reset, then REQ=001 and DONE 3 cycles after START_OP -> MS=00, GNT=001, one START_OP pulse, ACK=001 for one cycle, BUSY low after RELEASE.
REQ-031 REQ=111 held continuously, each requester dropping its bit on its ACK -> grants in order 0,1,2; MS sequence 00,01,10; no MS glitch within any transaction.
REQ-032 REQ=110 after a grant to 1 -> next grant to 2, then 1; MS=10 then 01.
REQ-033 DONE pulsed during LAUNCH and again 2 cycles later -> first pulse ignored, ACK only after the second.
REQ-034 With OPERAND_MUX_SCHEDULER_TIMEOUT_EN and TMO_CYCLES=4, no DONE -> ERR high for one cycle after 4 WAIT cycles, ACK=000; DONE on the 4th edge -> ACK instead of ERR.
REQ-035 RST_N pulled low during WAIT with GNT=010 -> all outputs at reset values immediately; after release, REQ=010 is granted again with MS=01.

Source files
------------

// File: rtl/operand_mux_scheduler.sv
// operand_mux_scheduler
// Round-robin scheduler that shares one FP unit among three requesters.
// It drives the operand mux select, a one-hot grant, the unit start pulse
// and one-cycle completion acknowledges. MS keeps the last winner until
// the next grant, so the operand path never glitches between transactions.
// Optional feature: define OPERAND_MUX_SCHEDULER_TIMEOUT_EN to build a WAIT
// timeout. It aborts the transaction with ERR after TMO_CYCLES WAIT cycles
// without DONE. In the default build ERR is tied low and no counter exists.
module operand_mux_scheduler #(
  parameter int unsigned TMO_CYCLES = 255,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] REQ,
  input  logic       DONE,
  output logic [1:0] MS,
  output logic [2:0] GNT,
  output logic       START_OP,
  output logic [2:0] ACK,
  output logic       ERR,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // The timeout must fit in the counter and be at least one cycle.
  if ((TMO_CYCLES < 1) || (TMO_CYCLES > (2 ** CNT_W) - 1)) begin : g_bad_cfg
    $error("operand_mux_scheduler: TMO_CYCLES out of range for CNT_W");
  end

  state_t     state_q, state_d;
  logic [1:0] ms_q, ms_d;
  logic [1:0] last_q, last_d;
  logic [2:0] gnt_q, gnt_d;
  logic       start_q, start_d;
  logic [2:0] ack_q, ack_d;
  logic       busy_q, busy_d;

`ifdef OPERAND_MUX_SCHEDULER_TIMEOUT_EN
  // The counter runs 0..TMO_CYCLES-1; the final WAIT edge sees TMO_LAST.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Successor index in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] next_idx(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Round-robin winner: the search begins just after the last granted index.
  function automatic logic [1:0] rr_pick(input logic [2:0] req,
                                         input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = 2'd0;
    found = 1'b0;
    idx   = next_idx(last);
    for (int i = 0; i < 3; i++) begin
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
      idx = next_idx(idx);
    end
    return win;
  endfunction

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    start_d = 1'b0;
    ack_d   = 3'b000;
`ifdef OPERAND_MUX_SCHEDULER_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|REQ) begin
          ms_d    = rr_pick(REQ, last_q);
          gnt_d   = 3'b001 << ms_d;
          start_d = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // DONE is ignored here; the unit cannot finish in its start cycle.
        state_d = S_WAIT;
`ifdef OPERAND_MUX_SCHEDULER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        // DONE takes priority over a timeout landing on the same edge.
        if (DONE) begin
          ack_d   = gnt_q;
          gnt_d   = 3'b000;
          last_d  = ms_q;
          state_d = S_RELEASE;
        end
`ifdef OPERAND_MUX_SCHEDULER_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          gnt_d   = 3'b000;
          last_d  = ms_q;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RELEASE: begin
        // REQ is not sampled here, so a requester dropping on ACK is skipped.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any transaction silently.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      ms_q    <= 2'd0;
      last_q  <= 2'd2;
      gnt_q   <= 3'b000;
      start_q <= 1'b0;
      ack_q   <= 3'b000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

`ifdef OPERAND_MUX_SCHEDULER_TIMEOUT_EN
  // Timeout counter and abort flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign MS       = ms_q;
  assign GNT      = gnt_q;
  assign START_OP = start_q;
  assign ACK      = ack_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_operand_mux_scheduler.sv
// Directed bench for operand_mux_scheduler with a queue-based scoreboard.
// The driver pushes the expected start and completion events of each
// transaction; a negedge monitor pops them as the DUT presents START_OP,
// ACK or ERR. It also watches that MS/GNT stay fixed between grants.
// The timeout cases are compiled when OPERAND_MUX_SCHEDULER_TIMEOUT_EN is set.
module tb_operand_mux_scheduler;

  typedef struct {
    bit         is_start;
    logic [1:0] ms;
    logic [2:0] gnt;
    logic [2:0] ack;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic       done;
  logic [1:0] ms;
  logic [2:0] gnt;
  logic       start_op;
  logic [2:0] ack;
  logic       err;
  logic       busy;

  exp_t       sbq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         have_ms = 0;
  logic [1:0] cur_ms = 2'd0;
  logic [2:0] cur_gnt = 3'd0;

  operand_mux_scheduler #(
    .TMO_CYCLES(4),
    .CNT_W     (8)
  ) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .REQ     (req),
    .DONE    (done),
    .MS      (ms),
    .GNT     (gnt),
    .START_OP(start_op),
    .ACK     (ack),
    .ERR     (err),
    .BUSY    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string name);
    check(name, {21'd0, ms, gnt, start_op, ack, err, busy}, 32'd0);
  endtask

  task automatic push_start(input int idx);
    exp_t e;
    e.is_start = 1'b1;
    e.ms       = 2'(idx);
    e.gnt      = 3'b001 << idx;
    e.ack      = 3'b000;
    e.err      = 1'b0;
    sbq.push_back(e);
  endtask

  task automatic push_done(input int idx, input bit tmo);
    exp_t e;
    e.is_start = 1'b0;
    e.ms       = 2'(idx);
    e.gnt      = 3'b000;
    e.ack      = tmo ? 3'b000 : (3'b001 << idx);
    e.err      = tmo;
    sbq.push_back(e);
  endtask

  // Bounded wait for the START_OP pulse; leaves the bench inside LAUNCH.
  task automatic wait_start(output bit ok);
    for (int t = 0; t < 20; t++) begin
      tick();
      if (start_op) break;
    end
    check("start_seen", {31'd0, start_op}, 32'd1);
    ok = start_op;
  endtask

  // One transaction: expected winner idx, DONE raised in cycle LAUNCH+n,
  // optional ignored DONE in LAUNCH, optional REQ rewrite after the grant,
  // or no DONE at all (timeout). Returns in the RELEASE cycle with the
  // winner's request bit dropped.
  task automatic txn(input int idx, input int n, input bit launch_done,
                     input bit chg, input logic [2:0] chg_req, input bit tmo);
    bit ok;
    int k;
    push_start(idx);
    push_done(idx, tmo);
    wait_start(ok);
    if (!ok) return;
    check("busy_launch", {31'd0, busy}, 32'd1);
    if (chg) req = chg_req;
    k = 0;
    if (launch_done) begin
      done = 1'b1;
      tick();
      done = 1'b0;
      k = 1;
      check("launch_done_ignored", {28'd0, err, ack}, 32'd0);
    end
    for (int i = k; i < n; i++) begin
      tick();
      check("wait_quiet", {28'd0, err, ack}, 32'd0);
    end
    if (!tmo) done = 1'b1;
    tick();
    done = 1'b0;
    req = req & ~(3'b001 << idx);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_ms = 0;
      end else begin
        if (start_op) begin
          if (sbq.size() == 0) begin
            check("start_unexpected", {31'd0, start_op}, 32'd0);
          end else begin
            e = sbq.pop_front();
            check("start_kind", {31'd0, e.is_start}, 32'd1);
            check("start_ms", {30'd0, ms}, {30'd0, e.ms});
            check("start_gnt", {29'd0, gnt}, {29'd0, e.gnt});
            cur_ms  = e.ms;
            cur_gnt = e.gnt;
            have_ms = 1;
          end
        end
        if ((ack != 3'b000) || err) begin
          if (sbq.size() == 0) begin
            check("done_unexpected", {28'd0, err, ack}, 32'd0);
          end else begin
            e = sbq.pop_front();
            check("done_kind", {31'd0, e.is_start}, 32'd0);
            check("done_ack", {29'd0, ack}, {29'd0, e.ack});
            check("done_err", {31'd0, err}, {31'd0, e.err});
          end
        end
        if (have_ms) check("ms_hold", {30'd0, ms}, {30'd0, cur_ms});
        if (gnt != 3'b000) check("gnt_hold", {29'd0, gnt}, have_ms ? {29'd0, cur_gnt} : 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n = 1'b0;
    req   = 3'b000;
    done  = 1'b0;
    repeat (2) tick();
    chk_reset("rst_hold");
    rst_n = 1'b1;
    tick();
    chk_reset("rst_idle");

    // Single request from 0, DONE three cycles after START_OP.
    req = 3'b001;
    txn(0, 3, 1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("gnt_idle", {29'd0, gnt}, 32'd0);

    // Fresh reset, then all three requesting: order 0,1,2.
    rst_n = 1'b0;
    #1;
    chk_reset("rst_again");
    tick();
    rst_n = 1'b1;
    req = 3'b111;
    txn(0, 2, 1'b0, 1'b0, 3'b000, 1'b0);
    txn(1, 2, 1'b0, 1'b0, 3'b000, 1'b0);
    txn(2, 2, 1'b0, 1'b0, 3'b000, 1'b0);
    check("req_drained", {29'd0, req}, 32'd0);

    // Grant to 1 with minimum turnaround, then 110 goes to 2 and back to 1.
    req = 3'b010;
    txn(1, 1, 1'b0, 1'b0, 3'b000, 1'b0);
    req = 3'b110;
    txn(2, 1, 1'b0, 1'b0, 3'b000, 1'b0);
    txn(1, 1, 1'b0, 1'b0, 3'b000, 1'b0);

    // DONE in LAUNCH is ignored; ACK follows the second pulse.
    req = 3'b001;
    txn(0, 2, 1'b1, 1'b0, 3'b000, 1'b0);

    // Owner drops its request and others rise during WAIT: no effect.
    req = 3'b100;
    txn(2, 3, 1'b0, 1'b1, 3'b011, 1'b0);
    req = 3'b000;
    tick();
    check("busy_after_drop", {31'd0, busy}, 32'd0);

    // Reset during WAIT with GNT=010, then the same request is regranted.
    push_start(1);
    req = 3'b010;
    wait_start(ok);
    tick();
    tick();
    check("gnt_wait_pre_rst", {29'd0, gnt}, 32'd2);
    check("busy_wait_pre_rst", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_async");
    tick();
    chk_reset("rst_async_hold");
    rst_n = 1'b1;
    txn(1, 2, 1'b0, 1'b0, 3'b000, 1'b0);

`ifdef OPERAND_MUX_SCHEDULER_TIMEOUT_EN
    // No DONE: ERR after four WAIT cycles; then DONE on the fourth edge wins.
    req = 3'b001;
    txn(0, 4, 1'b0, 1'b0, 3'b000, 1'b1);
    req = 3'b001;
    txn(0, 4, 1'b0, 1'b0, 3'b000, 1'b0);
`endif

    repeat (3) tick();
    check("busy_end", {31'd0, busy}, 32'd0);
    check("sb_drain", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
